countdown_timer: RTL

Countdown companion to the stopwatch: counts a loaded M:SS.th value down to 0:00.00 in 10 ms steps, then flags expiry.
- Digit chain uses borrow-out between BCD digits, the mirror of the stopwatch's rollover chain.
- Feeds the same seven-segment display path as the stopwatch.
- Contains its own clock prescaler and a control FSM.

---
 rtl/countdown_timer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable M:SS.th countdown in 10 ms steps with prescaler, control FSM and expiry flag.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on expiry and keep running.
module countdown_timer #(
  parameter int CLK_DIV = 1000000,
  parameter int DIV_WID = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  minutes,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic [3:0]  tenths,
  output logic [3:0]  hundredths,
  output logic        running,
  output logic        expired,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_WID-1:0] r_presc;
  logic [DIV_WID-1:0] w_presc_next;
  logic [19:0]        r_count;
  logic [19:0]        w_count_next;
  logic [19:0]        w_count_dec;
  logic [19:0]        w_load_clamped;
  logic [19:0]        w_reload_clamped;
  logic               r_running;
  logic               r_expired;
  logic               r_done;
  logic               w_done_next;
  logic               w_step;
  logic               w_at_one;
  logic               w_count_zero;
  logic               w_reload_active;

  // Digit index 3 is sec_tens (max 5); every other digit saturates at 9.
  function automatic logic [19:0] clampBcd(input logic [19:0] v);
    logic [19:0] c;
    logic [3:0]  dmax;
    c = v;
    for (int i = 0; i < 5; i++) begin
      dmax = (i == 3) ? 4'd5 : 4'd9;
      if (v[4*i +: 4] > dmax) c[4*i +: 4] = dmax;
    end
    return c;
  endfunction

  assign w_load_clamped = clampBcd(load_value);
  assign w_step         = (r_state == ST_RUNNING) && (r_presc == DIV_WID'(CLK_DIV - 1));
  assign w_at_one       = (r_count == 20'h00001);
  assign w_count_zero   = (r_count == 20'h00000);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [19:0] r_reload;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= load_value;
    end
  end

  assign w_reload_active  = (r_reload != 20'h00000);
  assign w_reload_clamped = clampBcd(r_reload);
`else
  assign w_reload_active  = 1'b0;
  assign w_reload_clamped = 20'h00000;
`endif

  // Borrow ripples from hundredths upward; a zero digit wraps to its max and passes the borrow on.
  always_comb begin
    logic       borrow;
    logic [3:0] dmax;
    w_count_dec = r_count;
    borrow      = w_step;
    dmax        = 4'd9;
    for (int i = 0; i < 5; i++) begin
      dmax = (i == 3) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_count_dec[4*i +: 4] = dmax;
        end else begin
          w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_count_next = w_count_dec;
    w_presc_next = r_presc;
    w_done_next  = 1'b0;

    if (r_state == ST_RUNNING) begin
      w_presc_next = w_step ? '0 : r_presc + DIV_WID'(1);
    end

    if (load) begin
      w_count_next = w_load_clamped;
      w_presc_next = '0;
      w_next_state = ST_IDLE;
    end else if (w_step && w_at_one) begin
      // Expiry outranks a coincident stop, except that a reloading timer honours it.
      w_done_next = 1'b1;
      if (w_reload_active) begin
        w_count_next = w_reload_clamped;
        w_next_state = stop ? ST_PAUSED : ST_RUNNING;
      end else begin
        w_next_state = ST_EXPIRED;
      end
    end else if (stop) begin
      if (r_state == ST_RUNNING) w_next_state = ST_PAUSED;
    end else if (start) begin
      if ((r_state == ST_IDLE || r_state == ST_PAUSED) && !w_count_zero) begin
        w_next_state = ST_RUNNING;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_presc   <= w_presc_next;
      r_count   <= w_count_next;
      r_running <= (w_next_state == ST_RUNNING);
      r_expired <= (w_next_state == ST_EXPIRED);
      r_done    <= w_done_next;
    end
  end

  assign minutes    = r_count[19:16];
  assign sec_tens   = r_count[15:12];
  assign sec_ones   = r_count[11:8];
  assign tenths     = r_count[7:4];
  assign hundredths = r_count[3:0];
  assign running    = r_running;
  assign expired    = r_expired;
  assign done       = r_done;

endmodule
